// File: rtl/wb_port_arbiter_if.sv
// Register-file write-port bundle: pipeline writeback request, multi-cycle result
// handshake and the registered write port itself.
interface wb_port_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);
  logic              pipe_valid;
  logic              pipe_regwrite;
  logic [REG_W-1:0]  pipe_rd;
  logic [DATA_W-1:0] pipe_data;
  logic              pipe_stall;

  // mc handshake: a result transfers on any cycle with mc_valid && mc_ready; mc_valid
  // must not depend on mc_ready, and mc_rd/mc_data are only meaningful while mc_valid.
  logic              mc_valid;
  logic [REG_W-1:0]  mc_rd;
  logic [DATA_W-1:0] mc_data;
  logic              mc_ready;

  logic              rf_we;
  logic [REG_W-1:0]  rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  logic              dbg_force;

  modport slave (
    input  pipe_valid, pipe_regwrite, pipe_rd, pipe_data,
    input  mc_valid, mc_rd, mc_data,
    output pipe_stall, mc_ready, rf_we, rf_waddr, rf_wdata, dbg_force
  );

  modport master (
    output pipe_valid, pipe_regwrite, pipe_rd, pipe_data,
    output mc_valid, mc_rd, mc_data,
    input  pipe_stall, mc_ready, rf_we, rf_waddr, rf_wdata, dbg_force
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the pipeline writeback stage and a
// small FIFO of multi-cycle results; an age counter forces a buffered result through.
module wb_port_arbiter #(
  parameter int DATA_W     = 32,
  parameter int REG_W      = 5,
  parameter int FIFO_DEPTH = 2,
  parameter int MAX_WAIT   = 4
) (
  input  logic             clk,
  input  logic             rst,
  wb_port_arbiter_if.slave bus
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int WC_W  = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(FIFO_DEPTH);
  localparam logic [WC_W-1:0]  MAX_WAIT_C = WC_W'(MAX_WAIT);

  typedef enum logic {ST_NORMAL, ST_FORCE} state_e;

  state_e            state_q, state_d;
  logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [REG_W-1:0]  fifo_rd_q   [FIFO_DEPTH];
  logic [REG_W-1:0]  fifo_rd_d   [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_d [FIFO_DEPTH];
  logic              rf_we_q, rf_we_d;
  logic [REG_W-1:0]  rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

  logic pipe_req, fifo_req, full, push, grant_pipe, grant_fifo;

  assign pipe_req   = bus.pipe_valid & bus.pipe_regwrite & (bus.pipe_rd != '0);
  assign fifo_req   = (count_q != '0);
  assign full       = (count_q == DEPTH_C);
  // Results addressed to x0 are accepted but never stored.
  assign push       = bus.mc_valid & ~full & (bus.mc_rd != '0);
  assign grant_pipe = (state_q == ST_NORMAL) & pipe_req;
  assign grant_fifo = fifo_req & ((state_q == ST_FORCE) | ~pipe_req);

  assign bus.mc_ready   = ~full;
  assign bus.pipe_stall = (state_q == ST_FORCE) & bus.pipe_valid;
  assign bus.rf_we      = rf_we_q;
  assign bus.rf_waddr   = rf_waddr_q;
  assign bus.rf_wdata   = rf_wdata_q;
  assign bus.dbg_force  = (state_q == ST_FORCE);

  always_comb begin
    fifo_rd_d   = fifo_rd_q;
    fifo_data_d = fifo_data_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (push) begin
      fifo_rd_d[wr_ptr_q]   = bus.mc_rd;
      fifo_data_d[wr_ptr_q] = bus.mc_data;
      wr_ptr_d              = wr_ptr_q + PTR_W'(1);
    end
    if (grant_fifo) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !grant_fifo)      count_d = count_q + CNT_W'(1);
    else if (!push && grant_fifo) count_d = count_q - CNT_W'(1);

    state_d    = ST_NORMAL;
    wait_cnt_d = wait_cnt_q;
    if (state_q == ST_FORCE || grant_fifo) begin
      wait_cnt_d = '0;
    end else if (pipe_req && fifo_req) begin
      if (wait_cnt_q != MAX_WAIT_C) wait_cnt_d = wait_cnt_q + WC_W'(1);
      // The edge that brings the age up to its limit moves the head onto the port next.
      if (wait_cnt_d == MAX_WAIT_C) state_d = ST_FORCE;
    end
    if (count_d == '0) wait_cnt_d = '0;

    rf_we_d    = grant_pipe | grant_fifo;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (grant_pipe) begin
      rf_waddr_d = bus.pipe_rd;
      rf_wdata_d = bus.pipe_data;
    end else if (grant_fifo) begin
      rf_waddr_d = fifo_rd_q[rd_ptr_q];
      rf_wdata_d = fifo_data_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_NORMAL;
      wait_cnt_q <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_rd_q[i]   <= '0;
        fifo_data_q[i] <= '0;
      end
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      fifo_rd_q   <= fifo_rd_d;
      fifo_data_q <= fifo_data_d;
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
    end
  end
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between two sources: the in-order pipeline writeback stage and a multi-cycle execution unit (mul/div) that returns results out of band.
- Multi-cycle results are held in a small FIFO.
- The pipeline normally has priority. An age counter forces the FIFO head onto the port and stalls the pipeline, so that buffered results cannot starve.
- Sits between the writeback-select mux output and the register file write port.

Parameters:
- DATA_W, 32, register data width
- REG_W, 5, register index width
- FIFO_DEPTH, 2, number of multi-cycle result entries held (power of two, ≥2)
- MAX_WAIT, 4, cycles the FIFO head may wait before a forced grant (≥1)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- pipe_valid  in  1  pipeline WB stage holds an instruction this cycle
- pipe_regwrite  in  1  that instruction writes a register
- pipe_rd  in  REG_W  pipeline destination register
- pipe_data  in  DATA_W  pipeline writeback value (already mux-selected)
- pipe_stall  out  1  pipeline must hold WB stage this cycle (combinational)
- mc_valid  in  1  multi-cycle unit presents a result
- mc_rd  in  REG_W  multi-cycle destination register
- mc_data  in  DATA_W  multi-cycle result
- mc_ready  out  1  FIFO can accept (combinational, = !full)
- rf_we  out  1  register-file write enable (registered)
- rf_waddr  out  REG_W  register-file write address (registered)
- rf_wdata  out  DATA_W  register-file write data (registered)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high.
- Reset values: rf_we=0, rf_waddr=0, rf_wdata=0, FIFO empty, wait_cnt=0, state=NORMAL.
- Reset mid-operation: buffered entries are discarded and no write is issued.
- Request qualification:
  - pipe_req = pipe_valid & pipe_regwrite & (pipe_rd≠0).
  - fifo_req = !empty.
  - Writes to x0 never reach the port.
- FIFO push:
  - An entry is pushed when mc_valid & mc_ready & (mc_rd≠0).
  - mc_valid & mc_ready with mc_rd=0 is accepted and dropped.
  - Push and pop in the same cycle are both legal. When full, mc_ready=0 and nothing pushes, even if a pop occurs that cycle.
- States:
  - NORMAL (the FIFO is never granted while pipe_req is high):
    - pipe_req=1: grant the pipe and pipe_stall=0. If fifo_req, wait_cnt increments (saturating at MAX_WAIT).
    - pipe_req=0 and fifo_req=1: grant the FIFO head (pop) and clear wait_cnt.
    - Neither: idle, rf_we=0 next cycle.
  - Transition NORMAL→FORCE occurs when wait_cnt==MAX_WAIT at a clock edge with fifo_req still 1.
  - FORCE:
    - Grant the FIFO head (pop) and pipe_stall=pipe_valid. The pipe request is held by the pipeline, not lost.
    - wait_cnt clears.
    - Return to NORMAL next cycle. Exactly one forced grant per entry into FORCE.
  - If the FIFO becomes empty while wait_cnt>0, wait_cnt clears.
- Output latency:
  - The granted source's rd/data appear on rf_waddr/rf_wdata with rf_we=1 on the cycle after the grant (1-cycle registered).
  - rf_waddr/rf_wdata hold their last value when rf_we=0.
- Stall: pipe_stall=0 in NORMAL. It is never asserted when pipe_valid=0.
- Ordering: FIFO entries are written in arrival order. The block does not reorder or check WAW hazards between sources; that is the issue logic's responsibility.
- One write per cycle maximum; rf_we never asserts for two grants in one cycle.

Test Plan:
- Reset then idle:
  - Stimulus: rst=1 for 2 cycles, all inputs 0.
  - Required: rf_we=0, mc_ready=1, pipe_stall=0. Asserting rst mid-write clears rf_we asynchronously.
- Pipe only:
  - Stimulus: pipe_valid=1, pipe_regwrite=1, pipe_rd=5, pipe_data=0xDEADBEEF.
  - Required: next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF.
  - Stimulus: pipe_rd=0.
  - Required: rf_we=0.
- MC into idle port:
  - Stimulus: mc_valid pulse with mc_rd=7, mc_data=0x12345678, pipe idle.
  - Required: push cycle N, grant cycle N+1, rf_we=1 with addr 7 and data 0x12345678 at cycle N+2.
- FIFO full:
  - Stimulus: pipe_req held high; push mc_rd=1 then mc_rd=2.
  - Required: mc_ready=0 after the second push. A third mc_valid is not accepted.
  - Stimulus: pipe drops.
  - Required: writes appear in order, addr 1 then addr 2; mc_ready returns to 1.
- Starvation force (MAX_WAIT=4):
  - Stimulus: one FIFO entry (rd=9), pipe_req continuously high with pipe_rd=3.
  - Required: 4 consecutive writes to addr 3, then FORCE with pipe_stall=1 for exactly one cycle and a write to addr 9, then writes to addr 3 resume with the stalled value unchanged.
- Simultaneous push/pop:
  - Stimulus: FIFO holds 1 entry, pipe idle, new mc_valid (rd=4) in the same cycle the head pops.
  - Required: head written, then the rd=4 entry written on the following grant; no entry lost or duplicated.
